shift_reg_bidir: RTL and testbench

Parametrised bidirectional shift register with rotate modes, parallel load, popcount output and a frame counter. Successor to the fixed-direction serial shift register. Sits between serial front-end logic and the display/decode stage: it collects or emits WIDTH-bit frames and flags each completed frame.

---
 rtl/shift_reg_defs.sv | 12 +
 rtl/popcount.sv | 19 +
 rtl/shift_reg_bidir.sv | 88 ++++++++
 tb/tb_shift_reg_bidir.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_defs.sv
// Shared definitions for the bidirectional shift register.
// Mode encodings used by the shifter and by the blocks that drive it.
package shift_reg_defs;

    typedef enum logic [1:0] {
        MODE_SHL = 2'b00,
        MODE_SHR = 2'b01,
        MODE_ROL = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

endpackage

// File: rtl/popcount.sv
// Combinational population count.
// Output is wide enough to hold WIDTH itself.
module popcount #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_bits,
    output logic [CNT_W-1:0] cnt
);

    // Sum every bit of the input vector.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(in_bits[i]);
        end
    end

endmodule

// File: rtl/shift_reg_bidir.sv
// Bidirectional shift/rotate register with parallel load,
// popcount and a registered frame-complete pulse.
module shift_reg_bidir
    import shift_reg_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [1:0]       mode,
    input  logic             data_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic [CNT_W-1:0] ones_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_q, frame_d;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

    // Next state: load wins over shift, shift wins over hold.
    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        frame_d = 1'b0;
        if (load) begin
            data_d = load_data;
            cnt_d  = '0;
        end else if (shift_en) begin
            unique case (mode_s)
                MODE_SHL: data_d = {data_q[WIDTH-2:0], data_in};
                MODE_SHR: data_d = {data_in, data_q[WIDTH-1:1]};
                MODE_ROL: data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                MODE_ROR: data_d = {data_q[0], data_q[WIDTH-1:1]};
                default:  data_d = data_q;
            endcase
            if (cnt_q == LAST_SHIFT) begin
                cnt_d   = '0;
                frame_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            cnt_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end

    // Outgoing bit depends on shift direction of the current mode.
    always_comb begin
        serial_out = data_q[0];
        if (mode_s == MODE_SHL || mode_s == MODE_ROL) begin
            serial_out = data_q[WIDTH-1];
        end
    end

    assign data_out   = data_q;
    assign frame_done = frame_q;

    popcount #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_popcount (
        .in_bits(data_q),
        .cnt    (ones_cnt)
    );

endmodule

// File: tb/tb_shift_reg_bidir.sv
// Self-checking bench for shift_reg_bidir (WIDTH=8).
// Arithmetic model plus directed literal checks.
module tb_shift_reg_bidir;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          shift_en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          data_in = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_data = '0;
    logic [W-1:0]  data_out;
    logic          serial_out;
    logic [CW-1:0] ones_cnt;
    logic          frame_done;

    int errors = 0;
    int checks = 0;

    int m_val = 0;
    int m_shifts = 0;
    bit m_frame = 1'b0;

    shift_reg_bidir #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (shift_en),
        .mode      (mode),
        .data_in   (data_in),
        .load      (load),
        .load_data (load_data),
        .data_out  (data_out),
        .serial_out(serial_out),
        .ones_cnt  (ones_cnt),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int ones_of(input int v);
        int n = 0;
        for (int i = 0; i < W; i++) n += (v >> i) & 1;
        return n;
    endfunction

    // Reference model: value as an integer 0..255, shifts as a running tally.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val = 0;
            m_shifts = 0;
            m_frame = 1'b0;
        end else begin
            m_frame = 1'b0;
            if (load) begin
                m_val = int'(load_data);
                m_shifts = 0;
            end else if (shift_en) begin
                case (mode)
                    2'b00: m_val = (m_val * 2 + int'(data_in)) % 256;
                    2'b01: m_val = m_val / 2 + int'(data_in) * 128;
                    2'b10: m_val = (m_val * 2) % 256 + m_val / 128;
                    default: m_val = m_val / 2 + (m_val % 2) * 128;
                endcase
                m_shifts++;
                if (m_shifts % W == 0) m_frame = 1'b1;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("cmp_data", int'(data_out), m_val);
        chk("cmp_ones", int'(ones_cnt), ones_of(m_val));
        chk("cmp_frame", int'(frame_done), int'(m_frame));
        chk("cmp_serial", int'(serial_out),
            (mode[0] == 1'b0) ? m_val / 128 : m_val % 2);
    end

    // Apply inputs, then take one edge; returns at edge + 1.
    task automatic cyc(input bit ld, input int ldd, input bit se,
                       input int md, input bit di);
        load = ld;
        load_data = W'(ldd);
        shift_en = se;
        mode = 2'(md);
        data_in = di;
        @(posedge clk);
        #1;
        load = 1'b0;
        shift_en = 1'b0;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_data", int'(data_out), 0);
        chk("rst_ones", int'(ones_cnt), 0);
        chk("rst_frame", int'(frame_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int pulses;
    int first_pulse;
    int second_pulse;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("init_data", int'(data_out), 0);
        rst_n = 1'b1;

        // Load and serial_out in both directions.
        cyc(1, 'hA5, 0, 0, 0);
        chk("load_a5", int'(data_out), 'hA5);
        chk("ones_a5", int'(ones_cnt), 4);
        chk("ser_shl", int'(serial_out), 1);
        mode = 2'b01;
        #1;
        chk("ser_shr", int'(serial_out), 1);

        // SHL then SHR.
        cyc(0, 0, 1, 0, 1);
        chk("shl_4b", int'(data_out), 'h4B);
        chk("ones_4b", int'(ones_cnt), 4);
        cyc(0, 0, 1, 1, 0);
        chk("shr_25", int'(data_out), 'h25);
        chk("ones_25", int'(ones_cnt), 3);

        // Eight ROR from 0x81 returns to 0x81 with one pulse.
        cyc(1, 'h81, 0, 3, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 1, 3, 0);
            chk("ror_frame", int'(frame_done), (i == 8) ? 1 : 0);
        end
        chk("ror_81", int'(data_out), 'h81);
        cyc(0, 0, 0, 3, 0);
        chk("hold_frame", int'(frame_done), 0);

        // Sixteen back-to-back shifts, two pulses 8 apart.
        pulses = 0;
        first_pulse = -1;
        second_pulse = -1;
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 0, 1, 2, 0);
            if (frame_done) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
                else second_pulse = i;
            end
        end
        chk("pulse_count", pulses, 2);
        chk("pulse_gap", second_pulse - first_pulse, 8);

        // Load beats shift and clears the counter.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1);
        cyc(1, 'h3C, 1, 0, 1);
        chk("load_prio", int'(data_out), 'h3C);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 1, 1, i[0]);
            chk("post_load_frame", int'(frame_done), (i == 8) ? 1 : 0);
        end

        // Reset while frame_done is high drops it at once.
        async_reset();

        // Partial frame discarded by reset.
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 1);
        async_reset();
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 1, 0, i[1]);
            chk("after_rst_frame", int'(frame_done), (i == 8) ? 1 : 0);
        end

        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
